// File: rtl/usb_ep_status_bus_if.sv
// CPU/CSR bus side of the endpoint status RAM bridge: request fields, read data
// and the single-cycle completion strobe.
interface usb_ep_status_bus_if;
  logic [7:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic [1:0]  bus_op;
  logic        bus_we;
  logic        bus_cyc;
  logic [15:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_addr, bus_wdata, bus_op, bus_we, bus_cyc,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_op, bus_we, bus_cyc,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/usb_ep_status_bus.sv
// Bus-slave bridge onto the endpoint status RAM aux port (fixed 3-cycle read latency).
// Define USB_EP_STATUS_BUS_RMW_EN to build the bit-set / bit-clear read-modify-write path.
module usb_ep_status_bus #(
  parameter int RD_LAT = 3
) (
  input  logic                clk,
  input  logic                rst,
  usb_ep_status_bus_if.slave  bus,
  output logic [7:0]          s_addr_0,
  output logic                s_read_0,
  output logic                s_zero_0,
  output logic                s_write_0,
  output logic [15:0]         s_din_0,
  input  logic [15:0]         s_dout_3,
  input  logic                s_ready_0
);

  localparam int            CW       = $clog2(RD_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT - 1);

`ifdef USB_EP_STATUS_BUS_RMW_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RMW_WR, ACK} state_t;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK} state_t;
`endif

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          read_reg, read_next;
  logic          write_reg, write_next;
  logic          ack_reg, ack_next;
  logic [7:0]    addr_reg, addr_next;
  logic [15:0]   din_reg, din_next;
  logic [15:0]   rdata_reg, rdata_next;
  logic          req_read;

`ifdef USB_EP_STATUS_BUS_RMW_EN
  logic          rmw_reg, rmw_next;
  logic          clr_reg, clr_next;
  logic [15:0]   mask_reg, mask_next;
  logic [15:0]   modified;
  logic          req_rmw;

  assign req_rmw  = bus.bus_we && (bus.bus_op == 2'b01 || bus.bus_op == 2'b10);
  assign req_read = !bus.bus_we || req_rmw;
  assign modified = clr_reg ? (s_dout_3 & ~mask_reg) : (s_dout_3 | mask_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rmw_reg  <= 1'b0;
      clr_reg  <= 1'b0;
      mask_reg <= '0;
    end else begin
      rmw_reg  <= rmw_next;
      clr_reg  <= clr_next;
      mask_reg <= mask_next;
    end
  end
`else
  logic unused_op;
  assign unused_op = ^bus.bus_op;
  assign req_read  = !bus.bus_we;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      ack_reg   <= 1'b0;
      addr_reg  <= '0;
      din_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      read_reg  <= read_next;
      write_reg <= write_next;
      ack_reg   <= ack_next;
      addr_reg  <= addr_next;
      din_reg   <= din_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    read_next  = read_reg;
    write_next = write_reg;
    ack_next   = 1'b0;
    addr_next  = addr_reg;
    din_next   = din_reg;
    rdata_next = rdata_reg;
`ifdef USB_EP_STATUS_BUS_RMW_EN
    rmw_next   = rmw_reg;
    clr_next   = clr_reg;
    mask_next  = mask_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        // ack_reg is never high here, but the guard documents that the ack cycle cannot start a command
        if (bus.bus_cyc && !ack_reg) begin
          addr_next  = bus.bus_addr;
          din_next   = bus.bus_wdata;
          rdata_next = '0;
          read_next  = req_read;
          write_next = !req_read;
`ifdef USB_EP_STATUS_BUS_RMW_EN
          rmw_next   = req_rmw;
          clr_next   = (bus.bus_op == 2'b10);
          mask_next  = bus.bus_wdata;
`endif
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (s_ready_0) begin
          read_next  = 1'b0;
          write_next = 1'b0;
          if (write_reg) begin
            ack_next   = 1'b1;
            state_next = ACK;
          end else begin
            cnt_next   = CNT_LOAD;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          // rdata keeps the pre-modify word for RMW so the ack reports it
          rdata_next = s_dout_3;
`ifdef USB_EP_STATUS_BUS_RMW_EN
          if (rmw_reg) begin
            din_next   = modified;
            write_next = 1'b1;
            state_next = RMW_WR;
          end else begin
            ack_next   = 1'b1;
            state_next = ACK;
          end
`else
          ack_next   = 1'b1;
          state_next = ACK;
`endif
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
`ifdef USB_EP_STATUS_BUS_RMW_EN
      RMW_WR: begin
        if (s_ready_0) begin
          write_next = 1'b0;
          ack_next   = 1'b1;
          state_next = ACK;
        end
      end
`endif
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign s_addr_0      = addr_reg;
  assign s_read_0      = read_reg;
  assign s_write_0     = write_reg;
  assign s_din_0       = din_reg;
  assign s_zero_0      = 1'b0;
  assign bus.bus_ack   = ack_reg;
  assign bus.bus_rdata = rdata_reg;

endmodule
